// File: rtl/hood_mode_scheduler_pkg.sv
// Shared types and helpers for the range-hood mode sequencer.
// The state codes match the ones used by the display/LED logic.
package hood_mode_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STBY    = 3'd1,
    ST_GEAR1   = 3'd2,
    ST_GEAR2   = 3'd3,
    ST_GEAR3   = 3'd4,
    ST_DLY_OFF = 3'd5,
    ST_CLEAN   = 3'd6
  } hood_state_e;

  function automatic logic [1:0] fan_of(input hood_state_e s);
    case (s)
      ST_GEAR1, ST_DLY_OFF: fan_of = 2'd1;
      ST_GEAR2:             fan_of = 2'd2;
      ST_GEAR3, ST_CLEAN:   fan_of = 2'd3;
      default:              fan_of = 2'd0;
    endcase
  endfunction

  function automatic logic is_timed(input hood_state_e s);
    is_timed = (s == ST_GEAR3) || (s == ST_CLEAN) || (s == ST_DLY_OFF);
  endfunction

endpackage

// File: rtl/hood_mode_scheduler_sec_tick_gen.sv
// One-second prescaler: tick is high for one cycle every TICK_DIV enabled cycles.
// Disabled or cleared, the count sits at zero so the next tick is a full period away.
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/hood_mode_scheduler.sv
// Range-hood mode sequencer: power/standby/gear/clean FSM with timed states,
// long-press detection, accumulated run time and a sticky service reminder.
module hood_mode_scheduler
  import hood_mode_scheduler_pkg::*;
#(
  parameter int TICK_DIV       = 100_000_000,
  parameter int HOLD_CYC       = 300_000_000,
  parameter int GEAR3_SEC      = 60,
  parameter int CLEAN_SEC      = 180,
  parameter int OFF_DELAY_SEC  = 180,
  parameter int WORK_LIMIT_SEC = 36000,
  parameter int WORK_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power_key,
  input  logic              menu_pls,
  input  logic              g1_pls,
  input  logic              g2_pls,
  input  logic              g3_pls,
  input  logic              clean_pls,
  output logic [2:0]        state,
  output logic              power_on,
  output logic [1:0]        fan_speed,
  output logic [7:0]        countdown,
  output logic [WORK_W-1:0] work_sec,
  output logic              reminder,
  output logic              gear3_used
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  hood_state_e       state_reg, state_next;
  logic              power_on_reg;
  logic [1:0]        fan_speed_reg;
  logic [7:0]        countdown_reg;
  logic [WORK_W-1:0] work_sec_reg;
  logic              reminder_reg;
  logic              gear3_used_reg;

  logic [HW-1:0]     hold_cnt_reg;
  logic              armed_reg;
  logic              lp;
  logic              tick;
  logic              expire;
  logic              load;
  logic              clean_done;
  logic              gear_run;
  logic [7:0]        load_val;
  logic [WORK_W-1:0] work_inc;

  // Long press fires once per hold; re-arms only after the key is released.
  assign lp = power_key && armed_reg && (hold_cnt_reg == HW'(HOLD_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
      armed_reg    <= 1'b1;
    end else if (!power_key) begin
      hold_cnt_reg <= '0;
      armed_reg    <= 1'b1;
    end else if (lp) begin
      hold_cnt_reg <= '0;
      armed_reg    <= 1'b0;
    end else if (armed_reg) begin
      hold_cnt_reg <= hold_cnt_reg + HW'(1);
    end
  end

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load),
    .en    (power_on_reg),
    .tick  (tick)
  );

  assign expire = tick && (countdown_reg == 8'd1);

  // A rejected g3 still claims its priority slot, so lower events are masked.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF: if (lp) state_next = ST_STBY;
      ST_STBY: begin
        if (lp)             state_next = ST_OFF;
        else if (clean_pls) state_next = ST_CLEAN;
        else if (g3_pls)    state_next = gear3_used_reg ? ST_STBY : ST_GEAR3;
        else if (g2_pls)    state_next = ST_GEAR2;
        else if (g1_pls)    state_next = ST_GEAR1;
      end
      ST_GEAR1, ST_GEAR2: begin
        if (lp || menu_pls) state_next = ST_DLY_OFF;
        else if (g3_pls)    state_next = gear3_used_reg ? state_reg : ST_GEAR3;
        else if (g2_pls)    state_next = ST_GEAR2;
        else if (g1_pls)    state_next = ST_GEAR1;
      end
      ST_GEAR3: begin
        if (lp || menu_pls) state_next = ST_DLY_OFF;
        else if (expire)    state_next = ST_GEAR2;
      end
      ST_DLY_OFF: begin
        if (lp)             state_next = ST_OFF;
        else if (g3_pls)    state_next = gear3_used_reg ? ST_DLY_OFF : ST_GEAR3;
        else if (g2_pls)    state_next = ST_GEAR2;
        else if (g1_pls)    state_next = ST_GEAR1;
        else if (expire)    state_next = ST_STBY;
      end
      ST_CLEAN: begin
        if (lp)                     state_next = ST_OFF;
        else if (menu_pls || expire) state_next = ST_STBY;
      end
      default: state_next = ST_OFF;
    endcase
  end

  assign load       = is_timed(state_next) && (state_next != state_reg);
  assign clean_done = (state_reg == ST_CLEAN) && !lp && !menu_pls && expire;
  assign gear_run   = (state_reg == ST_GEAR1) || (state_reg == ST_GEAR2) ||
                      (state_reg == ST_GEAR3);
  assign work_inc   = work_sec_reg + WORK_W'(1);

  always_comb begin
    load_val = 8'd0;
    case (state_next)
      ST_GEAR3:   load_val = 8'(GEAR3_SEC);
      ST_CLEAN:   load_val = 8'(CLEAN_SEC);
      ST_DLY_OFF: load_val = 8'(OFF_DELAY_SEC);
      default:    load_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_OFF;
      power_on_reg   <= 1'b0;
      fan_speed_reg  <= 2'd0;
      countdown_reg  <= 8'd0;
      work_sec_reg   <= '0;
      reminder_reg   <= 1'b0;
      gear3_used_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      power_on_reg  <= (state_next != ST_OFF);
      fan_speed_reg <= fan_of(state_next);

      if (load)                     countdown_reg <= load_val;
      else if (!is_timed(state_next)) countdown_reg <= 8'd0;
      else if (tick)                countdown_reg <= countdown_reg - 8'd1;

      if (state_next == ST_OFF)
        gear3_used_reg <= 1'b0;
      else if (state_reg == ST_GEAR3 && state_next != ST_GEAR3)
        gear3_used_reg <= 1'b1;

      if (clean_done) begin
        work_sec_reg <= '0;
        reminder_reg <= 1'b0;
      end else if (tick && gear_run && (work_sec_reg != '1)) begin
        work_sec_reg <= work_inc;
        if (work_inc == WORK_W'(WORK_LIMIT_SEC)) reminder_reg <= 1'b1;
      end
    end
  end

  assign state      = state_reg;
  assign power_on   = power_on_reg;
  assign fan_speed  = fan_speed_reg;
  assign countdown  = countdown_reg;
  assign work_sec   = work_sec_reg;
  assign reminder   = reminder_reg;
  assign gear3_used = gear3_used_reg;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Scoreboard bench for hood_mode_scheduler with short timing parameters.
module tb_hood_mode_scheduler;

  localparam int S_OFF = 0, S_STBY = 1, S_G1 = 2, S_G2 = 3, S_G3 = 4, S_DLY = 5, S_CLN = 6;

  logic        clk, rst_n;
  logic        power_key, menu_pls, g1_pls, g2_pls, g3_pls, clean_pls;
  logic [2:0]  state;
  logic        power_on;
  logic [1:0]  fan_speed;
  logic [7:0]  countdown;
  logic [31:0] work_sec;
  logic        reminder;
  logic        gear3_used;

  typedef struct {
    string name;
    int    st;
    int    cd;
    int    work;
    int    rem;
    int    used;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  hood_mode_scheduler #(
    .TICK_DIV(10), .HOLD_CYC(8), .GEAR3_SEC(6), .CLEAN_SEC(4),
    .OFF_DELAY_SEC(3), .WORK_LIMIT_SEC(5), .WORK_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power_key(power_key), .menu_pls(menu_pls),
    .g1_pls(g1_pls), .g2_pls(g2_pls), .g3_pls(g3_pls), .clean_pls(clean_pls),
    .state(state), .power_on(power_on), .fan_speed(fan_speed), .countdown(countdown),
    .work_sec(work_sec), .reminder(reminder), .gear3_used(gear3_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_fan(input int st);
    case (st)
      S_G1, S_DLY: return 1;
      S_G2:        return 2;
      S_G3, S_CLN: return 3;
      default:     return 0;
    endcase
  endfunction

  // Fields set to -1 are not compared.
  task automatic chk(input string name, input int st, input int cd,
                     input int work, input int rem, input int used);
    exp_t e;
    e.name = name; e.st = st; e.cd = cd; e.work = work; e.rem = rem; e.used = used;
    exp_q.push_back(e);
  endtask

  // Immediate check of all outputs against reset values.
  task automatic chk_now(input string name);
    bit bad;
    bad = (int'(state) != S_OFF) || (power_on !== 1'b0) || (int'(fan_speed) != 0) ||
          (int'(countdown) != 0) || (work_sec != 32'd0) || (reminder !== 1'b0) ||
          (gear3_used !== 1'b0);
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL %s: got st=%0d pwr=%0d fan=%0d cd=%0d work=%0d rem=%0d used=%0d, want all reset values",
               name, state, power_on, fan_speed, countdown, work_sec, reminder, gear3_used);
    end else begin
      $display("[TB] ok   %s: st=%0d fan=%0d cd=%0d work=%0d rem=%0d used=%0d",
               name, state, fan_speed, countdown, work_sec, reminder, gear3_used);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after any update.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        exp_t e;
        bit   bad;
        e = exp_q.pop_front();
        bad = (int'(state) != e.st) || (int'(power_on) != int'(e.st != S_OFF)) ||
              (int'(fan_speed) != exp_fan(e.st)) ||
              (e.cd   >= 0 && int'(countdown)  != e.cd) ||
              (e.work >= 0 && int'(work_sec)   != e.work) ||
              (e.rem  >= 0 && int'(reminder)   != e.rem) ||
              (e.used >= 0 && int'(gear3_used) != e.used);
        n_tests++;
        if (bad) begin
          n_fail++;
          $display("[TB] FAIL %s: got st=%0d pwr=%0d fan=%0d cd=%0d work=%0d rem=%0d used=%0d, want st=%0d fan=%0d cd=%0d work=%0d rem=%0d used=%0d",
                   e.name, state, power_on, fan_speed, countdown, work_sec, reminder, gear3_used,
                   e.st, exp_fan(e.st), e.cd, e.work, e.rem, e.used);
        end else begin
          $display("[TB] ok   %s: st=%0d fan=%0d cd=%0d work=%0d rem=%0d used=%0d",
                   e.name, state, fan_speed, countdown, work_sec, reminder, gear3_used);
        end
      end
    end
  end

  // Watchdog: the stimulus must finish within a bounded time.
  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL timeout: stimulus did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic c, input logic p1,
                       input logic p2, input logic p3);
    menu_pls = m; clean_pls = c; g1_pls = p1; g2_pls = p2; g3_pls = p3;
    cyc(1);
    menu_pls = 0; clean_pls = 0; g1_pls = 0; g2_pls = 0; g3_pls = 0;
  endtask

  task automatic lp_press(input int st_before, input int st_after);
    power_key = 1'b1;
    cyc(7);
    chk("lp_hold7", st_before, -1, -1, -1, -1);
    cyc(1);
    chk("lp_fire8", st_after, -1, -1, -1, -1);
    power_key = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst_n = 0; power_key = 0;
    menu_pls = 0; g1_pls = 0; g2_pls = 0; g3_pls = 0; clean_pls = 0;
    cyc(3);
    chk_now("reset_vals");
    rst_n = 1;
    cyc(2);

    // Power: one transition at hold cycle 8, none while still held
    power_key = 1'b1;
    cyc(7);  chk("pw_hold7", S_OFF, 0, 0, 0, 0);
    cyc(1);  chk("pw_on8", S_STBY, 0, 0, 0, 0);
    cyc(12); chk("pw_held20", S_STBY, 0, 0, 0, 0);
    power_key = 1'b0;
    cyc(1);
    lp_press(S_STBY, S_OFF);
    lp_press(S_OFF, S_STBY);

    // Reminder: prescaler free-runs, so any 40/50 cycle window holds 4/5 ticks
    pulse(0, 0, 0, 1, 0); chk("rm_g2", S_G2, 0, 0, 0, 0);
    cyc(40);              chk("rm_40", S_G2, 0, 4, 0, 0);
    cyc(10);              chk("rm_50", S_G2, 0, 5, 1, 0);
    pulse(1, 0, 0, 0, 0); chk("rm_dly", S_DLY, 3, -1, 1, 0);
    lp_press(S_DLY, S_OFF);
    chk("rm_off", S_OFF, 0, -1, 1, 0);
    lp_press(S_OFF, S_STBY);
    chk("rm_keep", S_STBY, 0, -1, 1, 0);
    pulse(0, 1, 0, 0, 0); chk("cl_entry", S_CLN, 4, -1, 1, 0);
    cyc(39);              chk("cl_39", S_CLN, 1, -1, 1, 0);
    cyc(1);               chk("cl_done", S_STBY, 0, 0, 0, 0);

    // Boost
    pulse(0, 0, 0, 0, 1); chk("b_entry", S_G3, 6, -1, -1, 0);
    cyc(59);              chk("b_59", S_G3, 1, -1, -1, 0);
    cyc(1);               chk("b_exp", S_G2, 0, -1, -1, 1);
    pulse(0, 0, 0, 0, 1); chk("b_g3_rej", S_G2, 0, -1, -1, 1);

    // Run-on
    pulse(0, 0, 1, 0, 0); chk("ro_g1", S_G1, 0, -1, -1, 1);
    pulse(1, 0, 0, 0, 0); chk("ro_dly", S_DLY, 3, -1, -1, 1);
    cyc(29);              chk("ro_29", S_DLY, 1, -1, -1, 1);
    cyc(1);               chk("ro_stby", S_STBY, 0, -1, -1, 1);
    pulse(0, 0, 1, 0, 0); chk("ro_g1b", S_G1, 0, -1, -1, 1);
    pulse(1, 0, 0, 0, 0); chk("ro_dlyb", S_DLY, 3, -1, -1, 1);
    cyc(14);              chk("ro_14", S_DLY, 2, -1, -1, 1);
    pulse(0, 0, 0, 1, 0); chk("ro_g2_15", S_G2, 0, -1, -1, 1);

    // Priority (power-cycle first so g3 would be accepted)
    lp_press(S_G2, S_DLY);
    lp_press(S_DLY, S_OFF);
    chk("pr_off_clr", S_OFF, 0, -1, -1, 0);
    lp_press(S_OFF, S_STBY);
    pulse(0, 0, 1, 0, 0); chk("pr_g1", S_G1, 0, -1, -1, 0);
    pulse(1, 0, 0, 0, 1); chk("pr_menu_g3", S_DLY, 3, -1, -1, 0);
    pulse(0, 0, 0, 0, 1); chk("pr_g3", S_G3, 6, -1, -1, 0);
    cyc(59);              chk("pr_g3_59", S_G3, 1, -1, -1, 0);
    pulse(1, 0, 0, 0, 0); chk("pr_menu_exp", S_DLY, 3, -1, -1, 1);

    // Asynchronous reset mid-CLEAN
    lp_press(S_DLY, S_OFF);
    lp_press(S_OFF, S_STBY);
    pulse(0, 1, 0, 0, 0); chk("rs_clean", S_CLN, 4, -1, -1, 0);
    cyc(20);              chk("rs_cd2", S_CLN, 2, -1, -1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_now("rs_async");
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
